cpu_mc_seq: RTL and testbench
=============================

Name: cpu_mc_seq

Overview:
- Parametrised multi-cycle sequencer for the next-generation RV32I core.
- Replaces the single-cycle assumption of combinational memory access.
- Drives fetch, decode, execute, memory and writeback as separate states against instruction/data memories with variable-latency ready handshakes.
- Owns PC, instruction register, gated register-file write enable, retire counting and bus-timeout trapping; sits between the Controller/EX datapath and the memory ports.

Parameters:
XLEN, 32, datapath/address width (32 or 64)
RESET_PC, 0, PC value loaded on reset
TIMEOUT, 255, max wait cycles for a memory ready before bus error (1..65535)
NOP_INST, 32'h0000_0013, instruction register reset value (addi x0,x0,0)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous active-high reset
run  in  1  1 = fetch new instructions; 0 = halt at next instruction boundary
imem_req  out  1  instruction fetch request
imem_addr  out  XLEN  fetch address (= pc)
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  32  fetched instruction
inst  out  32  latched instruction register
pc  out  XLEN  current PC
pc4  out  XLEN  pc + 4
npc  in  XLEN  next PC from EX
is_load  in  1  decoded load
is_store  in  1  decoded store
rf_we_in  in  1  Controller register-file write enable
dmem_req  out  1  data memory request
dmem_we  out  1  data write strobe (valid with dmem_req)
dmem_ready  in  1  data access complete
rf_we  out  1  gated register-file write enable
retire  out  1  one-cycle pulse per completed instruction
retire_cnt  out  64  retired instruction count
bus_err  out  1  sticky error flag
state  out  3  current FSM state (debug)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, and has priority over all other inputs.
- Reset values:
  - state=FETCH, pc=RESET_PC, inst=NOP_INST, retire_cnt=0.
  - bus_err=0, imem_req=dmem_req=dmem_we=rf_we=retire=0.
  - wait counter=0.
- Output style: all handshake and strobe outputs are Moore, decoded from registered state; no combinational input-to-output paths.
- pc4 = pc + 4, computed modulo 2^XLEN.
- States (encoding): FETCH=0, FWAIT=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERR=6.
- FETCH: if run=1, go to FWAIT; otherwise stay (halted). No outputs are asserted.
- FWAIT:
  - imem_req=1; imem_addr=pc, stable throughout.
  - On imem_ready: inst<=imem_rdata, go to DECODE.
  - imem_ready is sampled only in FWAIT; with zero-wait memory a fetch takes 2 cycles.
- DECODE: 1 cycle for register-file read to settle, then EXEC.
- EXEC: 1 cycle. If is_load|is_store, go to MEM; otherwise go to WB.
- MEM:
  - dmem_req=1, dmem_we=is_store.
  - On dmem_ready, go to WB.
  - If is_load and is_store are both 1, treat the access as a store.
- WB:
  - rf_we=rf_we_in for exactly this cycle; retire=1.
  - pc<=npc and retire_cnt<=retire_cnt+1, wrapping at 2^64.
  - Go to FETCH.
- Misaligned target: if npc[1:0]!=0 in WB, do not retire, do not update pc, force rf_we=0, and go to ERR.
- Timeout:
  - The wait counter clears on entry to FWAIT/MEM and increments each cycle without ready.
  - When it reaches TIMEOUT: go to ERR and set bus_err=1.
  - If ready coincides with the counter reaching TIMEOUT, ready wins.
- ERR: all requests and strobes are 0; bus_err stays 1; only reset exits.
- run=0 mid-instruction: the current instruction completes through WB, then the FSM holds in FETCH.
- Reset mid-access: any outstanding request is dropped; memories must tolerate an abandoned request.
- Minimum CPI is 5 (non-memory instruction) and 6 (memory instruction) with zero-wait memory.

Optional Feature:
- Macro: CPU_MC_SEQ_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - While run=0, a step=1 sample in FETCH executes exactly one instruction and returns to FETCH.
  - step is ignored outside FETCH and when run=1.
- When undefined: no step port; run alone controls fetch.

Decomposition:
- Shared package cpu_pkg:
  - State enum / localparams (FETCH..ERR).
  - NOP_INST constant.
  - XLEN default.
- Sub-module mc_wait_timer:
  - Loadable wait counter with clear, enable and expired outputs.
  - Instantiated once and reused for FWAIT and MEM.

Test Plan:
- Reset, run=1, zero-wait memories, 3 ALU instructions at RESET_PC=0 -> imem_addr 0,4,8; retire pulses at cycles 5,10,15 after reset release; retire_cnt=3.
- Load with dmem_ready delayed 3 cycles -> dmem_req high exactly 4 cycles, dmem_we=0, single rf_we pulse in WB, instruction takes 9 cycles.
- imem_ready never asserted, TIMEOUT=8 -> ERR after 8 FWAIT cycles; bus_err=1 sticky; imem_req=0; reset clears to FETCH with pc=0.
- Branch with npc=32'h0000_0102 -> no retire, rf_we=0, pc unchanged, bus_err=1; also npc=32'h0000_0100 -> pc=0x100 next fetch.
- run dropped during MEM of a store -> store completes, retire pulses once, FSM parks in FETCH with imem_req=0; run=1 resumes at npc.
- With CPU_MC_SEQ_STEP_EN, run=0: two step pulses -> retire_cnt increments by exactly 2, FSM parks in FETCH between them.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared constants for the multi-cycle RV32I sequencer.
package cpu_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_FWAIT  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;

endpackage

// File: rtl/mc_wait_timer.sv
// rtl/mc_wait_timer.sv - memory wait counter shared by the fetch and data waits.
module mc_wait_timer #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic expired
);

   logic [15:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + 16'd1;
      end
   end

   // High in the cycle whose missing ready would bring the count to TIMEOUT.
   assign expired = (cnt >= 16'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_mc_seq.sv
// rtl/cpu_mc_seq.sv - multi-cycle fetch/decode/exec/mem/wb sequencer.
// Optional single-step input enabled by CPU_MC_SEQ_STEP_EN.
module cpu_mc_seq
   import cpu_pkg::*;
#(
   parameter int               XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int               TIMEOUT  = 255,
   parameter logic [31:0]      NOP_INST = NOP_INST_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            run,
`ifdef CPU_MC_SEQ_STEP_EN
   input  logic            step,
`endif
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ready,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     inst,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc4,
   input  logic [XLEN-1:0] npc,
   input  logic            is_load,
   input  logic            is_store,
   input  logic            rf_we_in,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ready,
   output logic            rf_we,
   output logic            retire,
   output logic [63:0]     retire_cnt,
   output logic            bus_err,
   output logic [2:0]      state
);

   logic [2:0] state_nxt;
   logic       go;
   logic       waiting;
   logic       timer_en;
   logic       expired;
   logic       mem_we;
   logic       wb_ok;
   logic       wb_we;
   logic       npc_aligned;

`ifdef CPU_MC_SEQ_STEP_EN
   assign go = run | step;
`else
   assign go = run;
`endif

   assign npc_aligned = (npc[1:0] == 2'b00);
   assign waiting     = (state == S_FWAIT) || (state == S_MEM);

   mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (!waiting),
      .en      (timer_en),
      .expired (expired)
   );

   always_comb begin
      state_nxt = state;
      timer_en  = 1'b0;
      case (state)
         S_FETCH:  if (go) state_nxt = S_FWAIT;
         S_FWAIT: begin
            if (imem_ready)   state_nxt = S_DECODE;
            else if (expired) state_nxt = S_ERR;
            else              timer_en  = 1'b1;
         end
         S_DECODE: state_nxt = S_EXEC;
         S_EXEC:   state_nxt = (is_load || is_store) ? S_MEM : S_WB;
         S_MEM: begin
            if (dmem_ready)   state_nxt = S_WB;
            else if (expired) state_nxt = S_ERR;
            else              timer_en  = 1'b1;
         end
         S_WB:     state_nxt = wb_ok ? S_FETCH : S_ERR;
         default:  state_nxt = S_ERR;
      endcase
   end

   // WB strobes come from flags captured on WB entry so every output stays Moore.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= RESET_PC;
         inst       <= NOP_INST;
         retire_cnt <= '0;
         bus_err    <= 1'b0;
         mem_we     <= 1'b0;
         wb_ok      <= 1'b0;
         wb_we      <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_FWAIT && imem_ready) inst <= imem_rdata;
         if (state == S_EXEC) mem_we <= is_store;
         if (state_nxt == S_WB) begin
            wb_ok <= npc_aligned;
            wb_we <= rf_we_in && npc_aligned;
         end
         if (state == S_WB && wb_ok) begin
            pc         <= npc;
            retire_cnt <= retire_cnt + 64'd1;
         end
         if (state_nxt == S_ERR) bus_err <= 1'b1;
      end
   end

   assign imem_req  = (state == S_FWAIT);
   assign imem_addr = pc;
   assign pc4       = pc + XLEN'(4);
   assign dmem_req  = (state == S_MEM);
   assign dmem_we   = (state == S_MEM) && mem_we;
   assign rf_we     = (state == S_WB) && wb_we;
   assign retire    = (state == S_WB) && wb_ok;

endmodule

// File: tb/tb_cpu_mc_seq.sv
// tb/tb_cpu_mc_seq.sv - randomized self-checking bench for cpu_mc_seq.
module tb_cpu_mc_seq;

   localparam int TO = 8;

   logic        clk = 1'b0;
   logic        reset, run, step;
   logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready;
   logic [31:0] imem_addr, imem_rdata, inst, pc, pc4, npc;
   logic        is_load, is_store, rf_we_in, rf_we, retire, bus_err;
   logic [63:0] retire_cnt;
   logic [2:0]  state;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_pc;
   logic [63:0] m_cnt;

   always #5 clk = ~clk;

   cpu_mc_seq #(.XLEN(32), .RESET_PC(32'h0), .TIMEOUT(TO), .NOP_INST(32'h0000_0013)) dut (
      .clk        (clk),
      .reset      (reset),
      .run        (run),
`ifdef CPU_MC_SEQ_STEP_EN
      .step       (step),
`endif
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rdata (imem_rdata),
      .inst       (inst),
      .pc         (pc),
      .pc4        (pc4),
      .npc        (npc),
      .is_load    (is_load),
      .is_store   (is_store),
      .rf_we_in   (rf_we_in),
      .dmem_req   (dmem_req),
      .dmem_we    (dmem_we),
      .dmem_ready (dmem_ready),
      .rf_we      (rf_we),
      .retire     (retire),
      .retire_cnt (retire_cnt),
      .bus_err    (bus_err),
      .state      (state)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; run = 1'b0; step = 1'b0;
      imem_ready = 1'b0; dmem_ready = 1'b0; imem_rdata = '0;
      is_load = 1'b0; is_store = 1'b0; rf_we_in = 1'b0; npc = '0;
      repeat (2) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_pc", pc, 0);
      check("rst_inst", inst, 32'h0000_0013);
      check("rst_cnt", retire_cnt, 0);
      check("rst_strobes", {bus_err, imem_req, dmem_req, dmem_we, rf_we, retire}, 0);
      reset = 1'b0; run = 1'b1;
      m_pc = '0; m_cnt = '0;
   endtask

   // Called at the negedge of a FETCH cycle; runs one instruction to retire or error.
   task automatic run_inst(input int idly, input int mdly, input bit ld, input bit st,
                           input bit we, input logic [31:0] nv, input bit drop_run,
                           input bit use_step);
      logic [31:0] word;
      int  ncyc = 0, nireq = 0, ndreq = 0, nret = 0, nrfwe = 0;
      bit  mem, ef, em, ea, err, done = 0, saw_err = 0;
      mem = ld | st;
      ef  = (idly >= TO);
      em  = !ef && mem && (mdly >= TO);
      ea  = !ef && !em && (nv[1:0] != 2'b00);
      err = ef | em | ea;
      word = $urandom;
      imem_rdata = word; is_load = ld; is_store = st; rf_we_in = we; npc = nv;
      if (use_step) step = 1'b1;
      check("fetch_state", state, 0);
      while (!done && ncyc < 300) begin
         ncyc++;
         if (imem_req) begin
            nireq++;
            if (nireq == 1) check("imem_addr", imem_addr, m_pc);
            imem_ready = (nireq > idly);
         end else imem_ready = 1'b0;
         if (dmem_req) begin
            ndreq++;
            check("dmem_we", dmem_we, st);
            if (drop_run) run = 1'b0;
            dmem_ready = (ndreq > mdly);
         end else dmem_ready = 1'b0;
         if (rf_we) nrfwe++;
         if (retire) begin nret++; done = 1; end
         if (bus_err) begin
            saw_err = 1; done = 1;
            check("err_idle", {imem_req, dmem_req, rf_we, retire}, 0);
         end
         @(negedge clk);
         step = 1'b0;
      end
      imem_ready = 1'b0; dmem_ready = 1'b0;
      check("inst_done", done, 1);
      check("retire_pulses", nret, err ? 0 : 1);
      check("rf_we_pulses", nrfwe, (!err && we) ? 1 : 0);
      check("imem_req_cycles", nireq, ef ? TO : idly + 1);
      check("dmem_req_cycles", ndreq, (ef || !mem) ? 0 : (em ? TO : mdly + 1));
      check("bus_err", saw_err, err);
      if (!err) begin
         check("cycles", ncyc, 5 + idly + (mem ? mdly + 1 : 0));
         check("inst", inst, word);
         m_pc = nv;
         m_cnt++;
      end
      check("pc", pc, m_pc);
      check("pc4", pc4, m_pc + 32'd4);
      check("retire_cnt", retire_cnt, m_cnt);
      if (err) begin
         check("err_state", state, 6);
         repeat (3) @(negedge clk);
         check("err_sticky", {bus_err, imem_req, dmem_req, retire, state}, {4'b1000, 3'd6});
         do_reset();
      end
   endtask

   task automatic check_parked(input int n);
      for (int i = 0; i < n; i++) begin
         check("parked", {state, imem_req, dmem_req, retire}, 6'b000_000);
         @(negedge clk);
      end
   endtask

   initial begin
      do_reset();
      for (int i = 0; i < 3; i++) run_inst(0, 0, 0, 0, 1, m_pc + 32'd4, 0, 0);
      check("three_retired", retire_cnt, 3);
      run_inst(0, 3, 1, 0, 1, m_pc + 32'd4, 0, 0);
      run_inst(1, 2, 0, 1, 0, 32'h0000_0200, 1, 0);
      check_parked(4);
      run = 1'b1;
      run_inst(0, 0, 0, 0, 0, 32'h0000_0100, 0, 0);
      run_inst(7, 7, 1, 0, 1, m_pc + 32'd4, 0, 0);
      run_inst(0, 1, 1, 1, 1, m_pc + 32'd4, 0, 0);
      run_inst(1000, 0, 0, 0, 1, m_pc + 32'd4, 0, 0);
      run_inst(0, 1000, 1, 0, 1, m_pc + 32'd4, 0, 0);
      run_inst(0, 0, 0, 0, 1, 32'h0000_0040, 0, 0);
      run_inst(0, 0, 0, 0, 1, 32'h0000_0102, 0, 0);
      for (int i = 0; i < 40; i++) begin
         logic [31:0] r;
         r = $urandom;
         run_inst($urandom_range(0, 3), $urandom_range(0, 4), r[0], r[1], r[2],
                  {16'h0, r[17:4], 2'b00}, 0, 0);
      end
`ifdef CPU_MC_SEQ_STEP_EN
      do_reset();
      run = 1'b0;
      check_parked(3);
      run_inst(0, 0, 0, 0, 1, 32'h0000_0010, 0, 1);
      check_parked(3);
      run_inst(0, 2, 0, 1, 0, 32'h0000_0020, 0, 1);
      check_parked(3);
      check("step_cnt", retire_cnt, 2);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1, "watchdog");
   end

endmodule
